// File: rtl/fetch_monitor_if.sv
// Fetch-stage bundle: PC/control inputs, instruction memory port, decoder outputs and counters.
// master = fetch_monitor side, slave = PC stage / memory / testbench side.
interface fetch_monitor_if #(
    parameter int PCW = 16,
    parameter int IW  = 9,
    parameter int CW  = 32
);
    logic           start;
    logic           halt;
    logic           taken;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] imem_addr;
    logic [IW-1:0]  imem_data;
    logic [IW-1:0]  instr;
    logic [PCW-1:0] instr_pc;
    logic           valid;
    logic           done;
    logic [CW-1:0]  cycle_count;
    logic [CW-1:0]  instr_count;

    modport master (
        input  start, halt, taken, pc, imem_data,
        output imem_addr, instr, instr_pc, valid, done, cycle_count, instr_count
    );

    modport slave (
        output start, halt, taken, pc, imem_data,
        input  imem_addr, instr, instr_pc, valid, done, cycle_count, instr_count
    );
endinterface

// File: rtl/fetch_monitor.sv
// Instruction fetch with run/halt FSM and saturating perf counters; IMEM_ADDR 0-cycle, INSTR/VALID 1-cycle.
// No backpressure: START, HALT and TAKEN squash the fetch being registered this cycle.
module fetch_monitor #(
    parameter int            PCW = 16,
    parameter int            IW  = 9,
    parameter int            CW  = 32,
    parameter logic [IW-1:0] NOP = '0
) (
    input  logic            clk,
    input  logic            rst,
    fetch_monitor_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           f_valid;
    logic           f_valid_nxt;
    logic [PCW-1:0] f_pc;
    logic [CW-1:0]  cyc_cnt;
    logic [CW-1:0]  ins_cnt;
    logic           clr_cnt;
    logic           cyc_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // START outranks HALT, which outranks TAKEN; only a clean RUN cycle yields a valid fetch.
    always_comb begin
        state_nxt   = state;
        f_valid_nxt = 1'b0;
        clr_cnt     = 1'b0;
        cyc_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    clr_cnt = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.start) begin
                    state_nxt = IDLE;
                end else begin
                    cyc_inc = 1'b1;
                    if (bus.halt) begin
                        state_nxt = HALTED;
                    end else if (!bus.taken) begin
                        f_valid_nxt = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (bus.start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_valid <= 1'b0;
            f_pc    <= '0;
        end else begin
            f_valid <= f_valid_nxt;
            f_pc    <= bus.pc;
        end
    end

    // f_valid is never set outside RUN, so instruction counting stops on its own in HALTED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else if (clr_cnt) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            if (cyc_inc && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
            if (f_valid && (ins_cnt != '1)) begin
                ins_cnt <= ins_cnt + CW'(1);
            end
        end
    end

    assign bus.imem_addr   = bus.pc;
    assign bus.instr_pc    = f_pc;
    assign bus.valid       = f_valid;
    assign bus.instr       = f_valid ? bus.imem_data : NOP;
    assign bus.done        = (state == HALTED);
    assign bus.cycle_count = cyc_cnt;
    assign bus.instr_count = ins_cnt;

endmodule

// File: tb/tb_fetch_monitor.sv
// Bench for fetch_monitor: directed program table, halt/restart/reset/saturation sequences, random run vs model.
module tb_fetch_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_monitor_if #(.PCW(16), .IW(9), .CW(32)) dut_if ();
    fetch_monitor_if #(.PCW(16), .IW(9), .CW(4))  sat_if ();

    fetch_monitor #(.PCW(16), .IW(9), .CW(32)) u_dut (.clk(clk), .rst(rst), .bus(dut_if));
    fetch_monitor #(.PCW(16), .IW(9), .CW(4))  u_sat (.clk(clk), .rst(rst), .bus(sat_if));

    assign sat_if.start = dut_if.start;
    assign sat_if.halt  = dut_if.halt;
    assign sat_if.taken = dut_if.taken;
    assign sat_if.pc    = dut_if.pc;

    function automatic logic [8:0] mem(input logic [15:0] a);
        return 9'h010 + a[8:0];
    endfunction

    // Synchronous instruction memory: word for the address seen at an edge appears after it.
    always @(posedge clk) begin
        dut_if.imem_data <= mem(dut_if.imem_addr);
        sat_if.imem_data <= mem(sat_if.imem_addr);
    end

    // Reference model: program phase, the fetch in flight, and unbounded event counts.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_HALT} mode_t;
    mode_t       m_mode = M_IDLE;
    logic        m_fvalid = 1'b0;
    logic [15:0] m_fpc = '0;
    longint      m_cyc = 0;
    longint      m_ins = 0;

    function automatic logic [63:0] sat(input longint v, input longint lim);
        return 64'((v > lim) ? lim : v);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_fvalid = 1'b0; m_fpc = '0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic model_edge(input logic s, input logic h, input logic t, input logic [15:0] p);
        if (m_mode == M_IDLE && s) begin
            m_cyc = 0;
            m_ins = 0;
        end else begin
            if (m_mode == M_RUN && !s) m_cyc = m_cyc + 1;
            if (m_fvalid) m_ins = m_ins + 1;
        end
        m_fvalid = (m_mode == M_RUN) && !s && !h && !t;
        m_fpc    = p;
        if (s)                        m_mode = M_IDLE;
        else if (m_mode == M_IDLE)    m_mode = M_RUN;
        else if (m_mode == M_RUN && h) m_mode = M_HALT;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid",       64'(dut_if.valid),       64'(m_fvalid));
        chk("instr_pc",    64'(dut_if.instr_pc),    64'(m_fpc));
        chk("instr",       64'(dut_if.instr),       m_fvalid ? 64'(mem(m_fpc)) : 64'd0);
        chk("done",        64'(dut_if.done),        64'(m_mode == M_HALT));
        chk("cycle_count", 64'(dut_if.cycle_count), sat(m_cyc, 64'hFFFF_FFFF));
        chk("instr_count", 64'(dut_if.instr_count), sat(m_ins, 64'hFFFF_FFFF));
        chk("sat_cycle",   64'(sat_if.cycle_count), sat(m_cyc, 15));
        chk("sat_instr",   64'(sat_if.instr_count), sat(m_ins, 15));
    endtask

    // One clock: drive at negedge, check the combinational address, then check registered outputs.
    task automatic cyc(input logic s, input logic h, input logic t, input logic [15:0] p);
        dut_if.start = s;
        dut_if.halt  = h;
        dut_if.taken = t;
        dut_if.pc    = p;
        #1;
        chk("imem_addr", 64'(dut_if.imem_addr), 64'(p));
        model_edge(s, h, t, p);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic        s, h, t;
        logic [15:0] p;
        logic        v;
        logic [15:0] ipc;
        logic [8:0]  ins;
        logic        d;
        int          cc, ic;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  9'h000, 1'b0, 0,  0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  9'h000, 1'b0, 0,  0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  9'h000, 1'b0, 0,  0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  9'h000, 1'b0, 0,  0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd0,  9'h010, 1'b0, 1,  0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'd1,  1'b1, 16'd1,  9'h011, 1'b0, 2,  1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'd2,  1'b1, 16'd2,  9'h012, 1'b0, 3,  2};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'd3,  1'b1, 16'd3,  9'h013, 1'b0, 4,  3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'd4,  1'b1, 16'd4,  9'h014, 1'b0, 5,  4};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'd5,  1'b0, 16'd5,  9'h000, 1'b0, 6,  5};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'd40, 1'b1, 16'd40, 9'h038, 1'b0, 7,  5};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'd41, 1'b1, 16'd41, 9'h039, 1'b0, 8,  6};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 16'd42, 1'b1, 16'd42, 9'h03A, 1'b0, 9,  7};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 16'd43, 1'b0, 16'd43, 9'h000, 1'b1, 10, 8};

        dut_if.start = 1'b0;
        dut_if.halt  = 1'b0;
        dut_if.taken = 1'b0;
        dut_if.pc    = '0;

        // Reset values while RESET is held
        #3;
        chk("rst_valid",    64'(dut_if.valid),       64'd0);
        chk("rst_instr",    64'(dut_if.instr),       64'd0);
        chk("rst_instr_pc", 64'(dut_if.instr_pc),    64'd0);
        chk("rst_done",     64'(dut_if.done),        64'd0);
        chk("rst_cycle",    64'(dut_if.cycle_count), 64'd0);
        chk("rst_instr_ct", 64'(dut_if.instr_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Directed program: start pulse, sequential fetch, one taken branch, halt
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].s, tbl[i].h, tbl[i].t, tbl[i].p);
            chk($sformatf("tbl%0d_valid", i),    64'(dut_if.valid),       64'(tbl[i].v));
            chk($sformatf("tbl%0d_instr_pc", i), 64'(dut_if.instr_pc),    64'(tbl[i].ipc));
            chk($sformatf("tbl%0d_instr", i),    64'(dut_if.instr),       64'(tbl[i].ins));
            chk($sformatf("tbl%0d_done", i),     64'(dut_if.done),        64'(tbl[i].d));
            chk($sformatf("tbl%0d_cycle", i),    64'(dut_if.cycle_count), 64'(tbl[i].cc));
            chk($sformatf("tbl%0d_icount", i),   64'(dut_if.instr_count), 64'(tbl[i].ic));
        end

        // Halted: everything frozen for 20 cycles whatever HALT/TAKEN do
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'(100 + i));
            chk("halt_done",   64'(dut_if.done),        64'd1);
            chk("halt_valid",  64'(dut_if.valid),       64'd0);
            chk("halt_cycle",  64'(dut_if.cycle_count), 64'd10);
            chk("halt_icount", 64'(dut_if.instr_count), 64'd8);
        end

        // Restart from HALTED, new program at PC 214
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'd214);
        chk("restart_done",   64'(dut_if.done),        64'd0);
        chk("restart_cycle",  64'(dut_if.cycle_count), 64'd0);
        chk("restart_icount", 64'(dut_if.instr_count), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd214);
        chk("restart_bubble", 64'(dut_if.valid), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd214);
        chk("restart_valid",    64'(dut_if.valid),    64'd1);
        chk("restart_instr_pc", 64'(dut_if.instr_pc), 64'd214);
        chk("restart_instr",    64'(dut_if.instr),    64'h0E6);

        // Long run so the 4-bit counters pin at all-ones
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b0, 16'(215 + i));
        chk("sat_cycle_pin", 64'(sat_if.cycle_count), 64'hF);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 16'(240 + i));
        chk("sat_cycle_hold", 64'(sat_if.cycle_count), 64'hF);
        chk("sat_instr_hold", 64'(sat_if.instr_count), 64'hF);
        chk("wide_cycle",     64'(dut_if.cycle_count), 64'd31);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",  64'(dut_if.valid),       64'd0);
        chk("arst_instr",  64'(dut_if.instr),       64'd0);
        chk("arst_done",   64'(dut_if.done),        64'd0);
        chk("arst_cycle",  64'(dut_if.cycle_count), 64'd0);
        chk("arst_icount", 64'(dut_if.instr_count), 64'd0);
        chk("arst_sat",    64'(sat_if.cycle_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomised programs against the model
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 24) == 0),
                1'($urandom_range(0, 5) == 0),
                16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
